alu_muldiv_seq: RTL and testbench

- Multi-cycle sequencer that drives the team's 4-bit ALU (ctl 000 = ADD, 100 = SUB) to compute an unsigned WIDTH x WIDTH multiply or an unsigned WIDTH / WIDTH divide.
- Multiply uses shift-and-add; divide uses restoring division.
- Sits between a command source (start/ready handshake) and the shared ALU. It owns the ALU's a, b and ctl inputs and reads back z and cout.

---
 rtl/alu_muldiv_seq.sv | 152 +++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle sequencer for unsigned WIDTH x WIDTH multiply (shift-and-add)
// and WIDTH / WIDTH divide (restoring), driving an external combinational ALU.
// Result layout: MUL -> product, DIV -> {remainder, quotient}.
module alu_muldiv_seq #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               op,
   input  logic [WIDTH-1:0]   a_in,
   input  logic [WIDTH-1:0]   b_in,
   output logic               ready,
   output logic               done,
   output logic [2*WIDTH-1:0] result,
   output logic [WIDTH-1:0]   alu_a,
   output logic [WIDTH-1:0]   alu_b,
   output logic [2:0]         alu_ctl,
   input  logic [WIDTH-1:0]   alu_z,
   input  logic               alu_cout
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [2:0] CTL_ADD = 3'b000;
   localparam logic [2:0] CTL_SUB = 3'b100;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MADD,
      S_MSHR,
      S_DSHL,
      S_DSUB,
      S_DONE
   } state_t;

   state_t               state_q;
   logic [WIDTH-1:0]     acc_q;
   logic [WIDTH-1:0]     q_q;
   logic [WIDTH-1:0]     m_q;
   logic                 c_q;
   logic [CW-1:0]        cnt_q;
   logic [2*WIDTH-1:0]   result_q;
   logic                 restore_d;

   // Status flags and result decode straight from registered state.
   assign ready  = (state_q == S_IDLE);
   assign done   = (state_q == S_DONE);
   assign result = result_q;

   // A divide step keeps the difference when the shifted-out bit or the ALU
   // reports no borrow (the partial remainder was >= divisor).
   assign restore_d = c_q | alu_cout;

   // ALU operand/function drive: only the add and subtract states use the ALU.
   always_comb begin
      alu_a   = '0;
      alu_b   = '0;
      alu_ctl = CTL_ADD;
      case (state_q)
         S_MADD: begin
            alu_a   = acc_q;
            alu_b   = m_q;
            alu_ctl = CTL_ADD;
         end
         S_DSUB: begin
            alu_a   = acc_q;
            alu_b   = m_q;
            alu_ctl = CTL_SUB;
         end
         default: ;
      endcase
   end

   // Control FSM and datapath registers. result_q is loaded on the transition
   // into DONE with the final {ACC, Q}, so it is already valid while done=1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         q_q      <= '0;
         m_q      <= '0;
         c_q      <= 1'b0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  acc_q <= '0;
                  c_q   <= 1'b0;
                  cnt_q <= '0;
                  if (op) begin
                     q_q     <= a_in;
                     m_q     <= b_in;
                     state_q <= S_DSHL;
                  end else begin
                     m_q     <= a_in;
                     q_q     <= b_in;
                     state_q <= S_MADD;
                  end
               end
            end
            S_MADD: begin
               if (q_q[0]) begin
                  acc_q <= alu_z;
                  c_q   <= alu_cout;
               end else begin
                  c_q   <= 1'b0;
               end
               state_q <= S_MSHR;
            end
            S_MSHR: begin
               {acc_q, q_q} <= {c_q, acc_q, q_q[WIDTH-1:1]};
               c_q          <= 1'b0;
               if (cnt_q == CNT_LAST) begin
                  result_q <= {c_q, acc_q, q_q[WIDTH-1:1]};
                  state_q  <= S_DONE;
               end else begin
                  cnt_q   <= cnt_q + CW'(1);
                  state_q <= S_MADD;
               end
            end
            S_DSHL: begin
               {c_q, acc_q, q_q} <= {acc_q, q_q, 1'b0};
               state_q           <= S_DSUB;
            end
            S_DSUB: begin
               c_q <= 1'b0;
               if (restore_d) begin
                  acc_q  <= alu_z;
                  q_q[0] <= 1'b1;
               end
               if (cnt_q == CNT_LAST) begin
                  result_q <= restore_d ? {alu_z, q_q[WIDTH-1:1], 1'b1} : {acc_q, q_q};
                  state_q  <= S_DONE;
               end else begin
                  cnt_q   <= cnt_q + CW'(1);
                  state_q <= S_DSHL;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: attaches a behavioural 4-bit ALU, tracks each
// command with an arithmetic reference model and checks every cycle.
`timescale 1ns/1ps
module tb_alu_muldiv_seq;

   localparam int W = 4;

   logic           clk;
   logic           rst_n;
   logic           start;
   logic           op;
   logic [W-1:0]   a_in;
   logic [W-1:0]   b_in;
   logic           ready;
   logic           done;
   logic [2*W-1:0] result;
   logic [W-1:0]   alu_a;
   logic [W-1:0]   alu_b;
   logic [2:0]     alu_ctl;
   logic [W-1:0]   alu_z;
   logic           alu_cout;

   int checks = 0;
   int errors = 0;

   alu_muldiv_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op),
      .a_in(a_in), .b_in(b_in), .ready(ready), .done(done), .result(result),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl),
      .alu_z(alu_z), .alu_cout(alu_cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU: 000 = ADD, 100 = SUB (cout = 1 means no borrow).
   always_comb begin
      int s;
      if (alu_ctl == 3'b100) s = int'(alu_a) - int'(alu_b) + 16;
      else                   s = int'(alu_a) + int'(alu_b);
      alu_z    = W'(s);
      alu_cout = (s >= 16);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [2*W-1:0] ref_res(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
      if (!o)        return 8'(int'(a) * int'(b));
      else if (b==0) return {a, 4'hF};
      else           return {W'(a % b), W'(a / b)};
   endfunction

   // Reference model: p = clock edges since the accepting edge.
   logic           m_busy;
   int             m_p;
   logic           m_op;
   logic [W-1:0]   m_a, m_b;
   logic [2*W-1:0] res_exp;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy  <= 1'b0;
         m_p     <= 0;
         m_op    <= 1'b0;
         m_a     <= '0;
         m_b     <= '0;
         res_exp <= '0;
      end else if (!m_busy) begin
         if (start) begin
            m_busy <= 1'b1;
            m_p    <= 0;
            m_op   <= op;
            m_a    <= a_in;
            m_b    <= b_in;
         end
      end else begin
         if (m_p == 2*W) m_busy <= 1'b0;
         else            m_p    <= m_p + 1;
         if (m_p == 2*W-1) res_exp <= ref_res(m_op, m_a, m_b);
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      int i, hi, rem, ea, eb, ectl;
      ea = 0; eb = 0; ectl = 0;
      if (m_busy && m_p < 2*W) begin
         if (!m_op && (m_p % 2 == 0)) begin
            // Adding: ACC is the partial product of the low i multiplier bits, shifted down i.
            i    = m_p / 2;
            ea   = (int'(m_a) * (int'(m_b) % (1 << i))) >> i;
            eb   = int'(m_a);
            ectl = 0;
         end else if (m_op && (m_p % 2 == 1)) begin
            // Subtracting: ACC is 2*(remainder of top i dividend bits) + next bit.
            i    = (m_p - 1) / 2;
            hi   = int'(m_a) >> (W - i);
            rem  = (m_b == 0) ? hi : hi % int'(m_b);
            ea   = (rem * 2 + ((int'(m_a) >> (W - 1 - i)) & 1)) % 16;
            eb   = int'(m_b);
            ectl = 4;
         end
      end
      chk("ready",   32'(ready),   32'(!m_busy));
      chk("done",    32'(done),    32'(m_busy && m_p == 2*W));
      chk("result",  32'(result),  32'(res_exp));
      chk("alu_ctl", 32'(alu_ctl), 32'(ectl));
      chk("alu_a",   32'(alu_a),   32'(ea));
      chk("alu_b",   32'(alu_b),   32'(eb));
   end

   // Issue one command; optionally pulse a stray start mid-operation.
   task automatic run_cmd(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic stray, input logic b2b, input logic [2*W-1:0] lit);
      int n, cyc;
      @(negedge clk);
      if (b2b) chk("b2b_ready", 32'(ready), 32'd1);
      n = 0;
      while (!ready && n < 50) begin @(negedge clk); n++; end
      if (!ready) chk("ready_timeout", 32'(ready), 32'd1);
      op = o; a_in = a; b_in = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; a_in = W'($urandom); b_in = W'($urandom); op = 1'($urandom);
      cyc = 0;
      while (cyc < 30) begin
         @(negedge clk);
         cyc++;
         if (done) break;
         if (stray && cyc == 3) begin
            start = 1'b1; a_in = W'($urandom); b_in = W'($urandom);
            @(posedge clk); #1;
            start = 1'b0;
         end
      end
      chk("latency", 32'(cyc - 1), 32'(2*W));
      chk("result_lit", 32'(result), 32'(lit));
      chk("model_lit", 32'(res_exp), 32'(lit));
      $display("cmd op=%0d a=%0h b=%0h result=%0h expected=%0h", o, a, b, result, lit);
   endtask

   initial begin
      logic o;
      logic [W-1:0] a, b;
      rst_n = 1'b0; start = 1'b0; op = 1'b0; a_in = '0; b_in = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_alu", 32'({alu_a, alu_b, alu_ctl}), 32'd0);
      @(negedge clk); rst_n = 1'b1;

      run_cmd(1'b0, 4'hD, 4'hB, 1'b0, 1'b0, 8'h8F);
      run_cmd(1'b0, 4'hF, 4'hF, 1'b0, 1'b0, 8'hE1);
      run_cmd(1'b0, 4'h0, 4'h9, 1'b0, 1'b1, 8'h00);
      run_cmd(1'b1, 4'hD, 4'h3, 1'b0, 1'b0, 8'h14);
      run_cmd(1'b1, 4'hE, 4'h7, 1'b0, 1'b0, 8'h02);
      run_cmd(1'b1, 4'h9, 4'h0, 1'b0, 1'b0, 8'h9F);
      run_cmd(1'b0, 4'h5, 4'h6, 1'b1, 1'b0, 8'h1E);

      // Abort a divide mid-operation while a subtract is on the ALU.
      @(negedge clk);
      op = 1'b1; a_in = 4'hB; b_in = 4'h2; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_ready", 32'(ready), 32'd1);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_result", 32'(result), 32'd0);
      chk("abort_alu", 32'({alu_a, alu_b, alu_ctl}), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      run_cmd(1'b0, 4'h7, 4'h3, 1'b0, 1'b0, 8'h15);

      for (int k = 0; k < 40; k++) begin
         o = 1'($urandom); a = W'($urandom); b = W'($urandom);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         run_cmd(o, a, b, 1'($urandom_range(0, 3) == 0), 1'b0, ref_res(o, a, b));
      end
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
